// File: rtl/tanh_pwl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tanh_pwl_pipe
// Brief    : 3-stage valid/ready tanh unit, piecewise-linear or hard-clamp mode.
//            Optional saturation counter enabled by TANH_PWL_SAT_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tanh_pwl_pipe #(
    parameter int WIDTH = 8,
    parameter int FRAC  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef TANH_PWL_SAT_STATS_EN
    ,
    input  logic             sat_clr,
    output logic [15:0]      sat_count
`endif
);

    // Breakpoints and offsets in LSBs; all fit WIDTH bits since FRAC <= WIDTH-3.
    localparam logic [WIDTH-1:0] c_one    = WIDTH'(2**FRAC);
    localparam logic [WIDTH-1:0] c_half   = WIDTH'(2**(FRAC-1));
    localparam logic [WIDTH-1:0] c_two    = WIDTH'(2**(FRAC+1));
    localparam logic [WIDTH-1:0] c_eighth = WIDTH'((2**FRAC) / 8);
    localparam logic [WIDTH-1:0] c_nine16 = WIDTH'((9 * 2**FRAC) / 16);
    localparam logic [WIDTH-1:0] c_max    = WIDTH'(2**FRAC - 1);

    logic             w_en;
    logic [WIDTH-1:0] w_abs;
    logic [WIDTH-1:0] w_m;

    logic             r_v1, r_v2, r_v3;
    logic             r_s1, r_s2;
    logic             r_mode1;
    logic [WIDTH-1:0] r_a1;
    logic [WIDTH-1:0] r_m2;
    logic [WIDTH-1:0] r_y3;

    assign w_en      = ~r_v3 | out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_v3;
    assign out_data  = r_y3;

    // Unsigned magnitude: the most negative input wraps to 2^(WIDTH-1), which is exact.
    assign w_abs = in_data[WIDTH-1] ? ('0 - in_data) : in_data;

    // Segment sums stay below 2*ONE, so no intermediate exceeds WIDTH bits.
    always_comb begin
        w_m = '0;
        if (r_mode1) begin
            w_m = (r_a1 >= c_one) ? c_max : r_a1;
        end else if (r_a1 < c_half) begin
            w_m = r_a1 - (r_a1 >> 3);
        end else if (r_a1 < c_one) begin
            w_m = (r_a1 >> 1) + (r_a1 >> 3) + c_eighth;
        end else if (r_a1 < c_two) begin
            w_m = (r_a1 >> 3) + (r_a1 >> 4) + c_nine16;
        end else begin
            w_m = c_max;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_mode1 <= 1'b0;
            r_a1    <= '0;
            r_m2    <= '0;
            r_y3    <= '0;
        end else if (w_en) begin
            r_v1    <= in_valid;
            r_s1    <= in_data[WIDTH-1];
            r_mode1 <= in_mode;
            r_a1    <= w_abs;
            r_v2    <= r_v1;
            r_s2    <= r_s1;
            r_m2    <= w_m;
            r_v3    <= r_v2;
            r_y3    <= r_s2 ? ('0 - r_m2) : r_m2;
        end
    end

`ifdef TANH_PWL_SAT_STATS_EN
    logic w_sat;
    logic r_sat2, r_sat3;

    assign w_sat = r_mode1 ? (r_a1 >= c_one) : (r_a1 >= c_two);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sat2 <= 1'b0;
            r_sat3 <= 1'b0;
        end else if (w_en) begin
            r_sat2 <= w_sat;
            r_sat3 <= r_sat2;
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= 16'h0000;
        end else if (sat_clr) begin
            sat_count <= 16'h0000;
        end else if (r_v3 && out_ready && r_sat3 && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'h0001;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_tanh_pwl_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_tanh_pwl_pipe
// Brief    : Self-checking bench for tanh_pwl_pipe with an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tanh_pwl_pipe;
    localparam int WIDTH = 8;
    localparam int FRAC  = 5;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             in_mode   = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] in_data   = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
`ifdef TANH_PWL_SAT_STATS_EN
    logic             sat_clr   = 1'b0;
    logic [15:0]      sat_count;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tanh_pwl_pipe #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef TANH_PWL_SAT_STATS_EN
        ,
        .sat_clr   (sat_clr),
        .sat_count (sat_count)
`endif
    );

    // Real-valued tanh approximation evaluated on integer LSB counts.
    function automatic int ref_tanh(input int x, input bit mode);
        int one;
        int a;
        int m;
        one = 2 ** FRAC;
        a   = (x < 0) ? -x : x;
        if (mode)             m = (a < one) ? a : one - 1;
        else if (2 * a < one) m = a - a / 8;
        else if (a < one)     m = a / 2 + a / 8 + one / 8;
        else if (a < 2 * one) m = a / 8 + a / 16 + (9 * one) / 16;
        else                  m = one - 1;
        return (x < 0) ? -m : m;
    endfunction

    function automatic int dut_y();
        return int'($signed(out_data));
    endfunction

    task automatic drive(input logic v, input int x, input logic m, input logic rdy);
        @(negedge clk);
        in_valid  = v;
        in_data   = WIDTH'(x);
        in_mode   = m;
        out_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++;
        if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%0d want=0", dut_y()); end
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_pwl_basic();
        int xs[5] = '{8, 16, 24, 32, 48};
        int ys[5] = '{7, 14, 19, 24, 27};
        int q_exp[$];
        int q_cyc[$];
        int sent = 0;
        int got  = 0;
        for (int c = 0; c < 40 && got < 5; c++) begin
            drive(sent < 5, (sent < 5) ? xs[sent] : 0, 1'b0, 1'b1);
            if (out_valid && out_ready) begin
                checks++;
                if (q_exp.size() == 0) begin failures++; $display("FAIL pwl_basic_spurious got=%0d", dut_y()); end
                else begin
                    if (dut_y() !== q_exp[0]) begin failures++; $display("FAIL pwl_basic_value got=%0d want=%0d", dut_y(), q_exp[0]); end
                    checks++;
                    if (cyc - q_cyc[0] != 3) begin failures++; $display("FAIL pwl_basic_latency got=%0d want=3", cyc - q_cyc[0]); end
                    void'(q_exp.pop_front()); void'(q_cyc.pop_front());
                end
                got++;
            end
            if (in_valid && in_ready) begin q_exp.push_back(ys[sent]); q_cyc.push_back(cyc); sent++; end
        end
        checks++;
        if (got != 5) begin failures++; $display("FAIL pwl_basic_timeout got=%0d want=5", got); end
    endtask

    task automatic test_pwl_boundaries();
        int xs[6] = '{15, 31, 63, 64, -96, -128};
        int ys[6] = '{14, 22, 28, 31, -31, -31};
        int q_exp[$];
        int sent = 0;
        int got  = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            drive(sent < 6, (sent < 6) ? xs[sent] : 0, 1'b0, 1'b1);
            if (out_valid && out_ready) begin
                checks++;
                if (q_exp.size() == 0) begin failures++; $display("FAIL pwl_bound_spurious got=%0d", dut_y()); end
                else begin
                    if (dut_y() !== q_exp[0]) begin failures++; $display("FAIL pwl_bound_value got=%0d want=%0d", dut_y(), q_exp[0]); end
                    void'(q_exp.pop_front());
                end
                got++;
            end
            if (in_valid && in_ready) begin q_exp.push_back(ys[sent]); sent++; end
        end
        checks++;
        if (got != 6) begin failures++; $display("FAIL pwl_bound_timeout got=%0d want=6", got); end
    endtask

    task automatic test_hard_mode();
        int   xs[6] = '{16, 48, -40, 0, 48, 48};
        logic ms[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int   ys[6] = '{16, 31, -31, 0, 27, 31};
        int q_exp[$];
        int sent = 0;
        int got  = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            drive(sent < 6, (sent < 6) ? xs[sent] : 0, (sent < 6) ? ms[sent] : 1'b0, 1'b1);
            if (out_valid && out_ready) begin
                checks++;
                if (q_exp.size() == 0) begin failures++; $display("FAIL hard_spurious got=%0d", dut_y()); end
                else begin
                    if (dut_y() !== q_exp[0]) begin failures++; $display("FAIL hard_value got=%0d want=%0d", dut_y(), q_exp[0]); end
                    void'(q_exp.pop_front());
                end
                got++;
            end
            if (in_valid && in_ready) begin q_exp.push_back(ys[sent]); sent++; end
        end
        checks++;
        if (got != 6) begin failures++; $display("FAIL hard_timeout got=%0d want=6", got); end
    endtask

    task automatic test_backpressure();
        int   q_exp[$];
        int   xs[20];
        logic ms[20];
        int   sent = 0;
        int   got  = 0;
        int   extra = 0;
        logic stalled = 1'b0;
        logic [WIDTH-1:0] held = '0;
        for (int i = 0; i < 20; i++) begin
            xs[i] = int'($urandom_range(0, 255)) - 128;
            ms[i] = 1'($urandom_range(0, 1));
        end
        for (int c = 0; c < 80 && got < 20; c++) begin
            drive(sent < 20, (sent < 20) ? xs[sent] : 0, (sent < 20) ? ms[sent] : 1'b0, !(c >= 6 && c < 11));
            if (!out_ready && out_valid) begin
                checks++;
                if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b want=0", in_ready); end
                if (stalled) begin
                    checks++;
                    if (out_data !== held) begin failures++; $display("FAIL bp_hold got=%0d want=%0d", dut_y(), $signed(held)); end
                end
            end
            stalled = !out_ready && out_valid;
            held    = out_data;
            if (out_valid && out_ready) begin
                checks++;
                if (q_exp.size() == 0) begin failures++; $display("FAIL bp_spurious got=%0d", dut_y()); end
                else begin
                    if (dut_y() !== q_exp[0]) begin failures++; $display("FAIL bp_value got=%0d want=%0d", dut_y(), q_exp[0]); end
                    void'(q_exp.pop_front());
                end
                got++;
            end
            if (in_valid && in_ready) begin q_exp.push_back(ref_tanh(xs[sent], ms[sent])); sent++; end
        end
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 0, 1'b0, 1'b1);
            if (out_valid) extra++;
        end
        checks++;
        if (got != 20 || extra != 0) begin failures++; $display("FAIL bp_count got=%0d extra=%0d want=20 extra=0", got, extra); end
    endtask

    task automatic test_random();
        int q_exp[$];
        int sent = 0;
        int got  = 0;
        int x;
        logic m;
        for (int c = 0; c < 400 && got < 60; c++) begin
            x = int'($urandom_range(0, 255)) - 128;
            m = 1'($urandom_range(0, 1));
            drive((sent < 60) && ($urandom_range(0, 3) != 0), x, m, $urandom_range(0, 9) < 7);
            if (out_valid && out_ready) begin
                checks++;
                if (q_exp.size() == 0) begin failures++; $display("FAIL rand_spurious got=%0d", dut_y()); end
                else begin
                    if (dut_y() !== q_exp[0]) begin failures++; $display("FAIL rand_value got=%0d want=%0d", dut_y(), q_exp[0]); end
                    void'(q_exp.pop_front());
                end
                got++;
            end
            if (in_valid && in_ready) begin q_exp.push_back(ref_tanh(x, m)); sent++; end
        end
        checks++;
        if (got != 60) begin failures++; $display("FAIL rand_timeout got=%0d want=60", got); end
    endtask

    task automatic test_reset_midstream();
        int seen = 0;
        int acc_cyc = 0;
        drive(1'b1, 40, 1'b0, 1'b1);
        drive(1'b1, -50, 1'b1, 1'b1);
        drive(1'b1, 100, 1'b0, 1'b1);
        drive(1'b0, 0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL rst_mid_full got=%b want=1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b want=0", out_valid); end
        checks++;
        if (out_data !== '0) begin failures++; $display("FAIL rst_mid_data got=%0d want=0", dut_y()); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, -20, 1'b0, 1'b1);
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_accept got=%b want=1", in_ready); end
        acc_cyc = cyc;
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 0, 1'b0, 1'b1);
            if (out_valid) begin
                seen++;
                checks++;
                if (dut_y() !== -16 || cyc - acc_cyc != 3) begin
                    failures++; $display("FAIL rst_mid_after got=%0d@%0d want=-16@3", dut_y(), cyc - acc_cyc);
                end
            end
        end
        checks++;
        if (seen != 1) begin failures++; $display("FAIL rst_mid_count got=%0d want=1", seen); end
    endtask

`ifdef TANH_PWL_SAT_STATS_EN
    task automatic test_sat_stats();
        int xs[8] = '{100, 10, -100, 127, 10, -128, 20, 64};
        int sent = 0;
        int got  = 0;
        @(negedge clk); sat_clr = 1'b1;
        @(negedge clk); sat_clr = 1'b0;
        for (int c = 0; c < 40 && got < 8; c++) begin
            drive(sent < 8, (sent < 8) ? xs[sent] : 0, 1'b0, 1'b1);
            if (out_valid && out_ready) got++;
            if (in_valid && in_ready) sent++;
        end
        drive(1'b0, 0, 1'b0, 1'b1);
        checks++;
        if (sat_count !== 16'd5) begin failures++; $display("FAIL sat_count5 got=%0d want=5", sat_count); end
        drive(1'b1, 100, 1'b0, 1'b1);
        for (int c = 0; c < 10 && !out_valid; c++) drive(1'b0, 0, 1'b0, 1'b1);
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        checks++;
        if (sat_count !== 16'd0) begin failures++; $display("FAIL sat_clr_prio got=%0d want=0", sat_count); end
        @(negedge clk);
        in_valid = 1'b1; in_data = WIDTH'(-128); in_mode = 1'b1; out_ready = 1'b1;
        repeat (70010) @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (sat_count !== 16'hFFFF) begin failures++; $display("FAIL sat_saturate got=%h want=ffff", sat_count); end
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_pwl_basic();
        test_pwl_boundaries();
        test_hard_mode();
        test_backpressure();
        test_random();
        test_reset_midstream();
`ifdef TANH_PWL_SAT_STATS_EN
        test_sat_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
